// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and
// the line levels of the start and stop bits.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS_DEF    = 10;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, valid/ready word out, status flags.
// The receiver drives the word and flags (master); the consumer drives the
// serial line and the ready (slave).
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);

    logic                 rx_in;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 busy;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        input  rx_in,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output busy,
        output frame_err,
        output overrun
    );

    modport slave (
        output rx_in,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input plus a falling-edge
// detector on the synchronized value. All flops reset to 1 so an idle-high
// line never produces a spurious edge when reset is released.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability chain followed by a one-cycle history of the clean value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing, mid-bit sampling at CLKS_PER_BIT
// oversampling, one-entry valid/ready holding register, and single-cycle
// framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // Start is sampled half a bit after the edge, every later bit one full
    // bit period after the previous sample point.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 2) begin : g_bad_bits
        $error("uart_rx: DATA_BITS must be >= 2");
    end

    logic w_rx_s;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.rx_in),
        .o_sync  (w_rx_s),
        .o_fall  (w_fall)
    );

    uart_state_t          r_state,     w_state_nxt;
    logic [CNT_W-1:0]     r_clk_cnt,   w_clk_cnt_nxt;
    logic [IDX_W-1:0]     r_bit_idx,   w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,      w_data_nxt;
    logic                 r_valid,     w_valid_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 r_overrun,   w_overrun_nxt;
    logic                 w_consume;

    assign w_consume = r_valid & bus.rx_ready;

    // Next-state logic: frame sequencing, bit sampling and holding-register update.
    always_comb begin
        w_state_nxt     = r_state;
        w_clk_cnt_nxt   = r_clk_cnt + CNT_W'(1);
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid & ~w_consume;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                // Only a genuine 1->0 transition arms a frame, so a line held
                // low after a framing error (break) stays ignored.
                w_clk_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_clk_cnt == HALF_LAST) begin
                    w_clk_cnt_nxt = '0;
                    if (w_rx_s == START_BIT) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (r_clk_cnt == BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    // LSB arrives first; shifting in at the top leaves it in bit 0.
                    w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (r_clk_cnt == BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                    if (w_rx_s == STOP_BIT) begin
                        // A word being consumed this cycle frees the slot, so
                        // load-and-consume keeps rx_valid high without overrun.
                        if (!r_valid || w_consume) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_clk_cnt_nxt = '0;
            end
        endcase
    end

    // State, counter, shift and holding registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.busy      = (r_state != IDLE);
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven bit by bit, expected
// words queued at stimulus time and matched against accepted transfers.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 10;

    logic clk;
    logic rst;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] rcv_q[$];
    int            rcv_rd = 0;
    logic [DB-1:0] exp_w;
    logic [DB-1:0] got_w;

    int busy_cnt  = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int both_cnt  = 0;

    int b_busy, b_valid, b_ferr, b_ovr;

    // Monitor: records accepted words and flag activity, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rx_valid && bus.rx_ready) rcv_q.push_back(bus.rx_data);
            if (bus.busy)      busy_cnt++;
            if (bus.rx_valid)  valid_cnt++;
            if (bus.frame_err) ferr_cnt++;
            if (bus.overrun)   ovr_cnt++;
            if (bus.frame_err && bus.overrun) both_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic snap();
        b_busy  = busy_cnt;
        b_valid = valid_cnt;
        b_ferr  = ferr_cnt;
        b_ovr   = ovr_cnt;
    endtask

    task automatic hold_bit(input logic b);
        bus.rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Line is left at the stop-bit level when the task returns.
    task automatic send_frame(input logic [DB-1:0] w, input logic stop_b);
        @(posedge clk);
        #1;
        hold_bit(1'b0);
        for (int i = 0; i < DB; i++) hold_bit(w[i]);
        hold_bit(stop_b);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rx_in = 1'b1;
        bus.rx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (bus.rx_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", bus.rx_valid); errors++; end
        checks++;
        if (bus.rx_data !== '0) begin $display("FAIL reset_data got=%h exp=000", bus.rx_data); errors++; end
        checks++;
        if (bus.busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", bus.busy); errors++; end
        checks++;
        if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            $display("FAIL reset_flags got=%b%b exp=00", bus.frame_err, bus.overrun); errors++;
        end
        checks++;
        rst = 1'b1;
        snap();
        repeat (20) @(posedge clk);
        #1;
        if (busy_cnt - b_busy !== 0) begin $display("FAIL reset_release_busy got=%0d exp=0", busy_cnt - b_busy); errors++; end
        checks++;
    endtask

    task automatic test_single();
        bus.rx_ready = 1'b1;
        snap();
        exp_q.push_back(10'h2A5);
        send_frame(10'h2A5, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        if (busy_cnt - b_busy !== 184) begin $display("FAIL single_busy_cycles got=%0d exp=184", busy_cnt - b_busy); errors++; end
        checks++;
        if (valid_cnt - b_valid !== 1) begin $display("FAIL single_valid_cycles got=%0d exp=1", valid_cnt - b_valid); errors++; end
        checks++;
        if (ferr_cnt - b_ferr !== 0 || ovr_cnt - b_ovr !== 0) begin
            $display("FAIL single_flags got ferr=%0d ovr=%0d exp 0 0", ferr_cnt - b_ferr, ovr_cnt - b_ovr); errors++;
        end
        checks++;
        if (rcv_q.size() !== rcv_rd + 1) begin $display("FAIL single_count got=%0d exp=1", rcv_q.size() - rcv_rd); errors++; end
        checks++;
        while (exp_q.size() > 0 && rcv_rd < rcv_q.size()) begin
            exp_w = exp_q.pop_front(); got_w = rcv_q[rcv_rd]; rcv_rd++;
            if (got_w !== exp_w) begin $display("FAIL single_data got=%h exp=%h", got_w, exp_w); errors++; end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        bus.rx_ready = 1'b0;
        snap();
        exp_q.push_back(10'h3FF);
        send_frame(10'h3FF, 1'b1);
        send_frame(10'h001, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        if (ovr_cnt - b_ovr !== 1) begin $display("FAIL b2b_overrun_cycles got=%0d exp=1", ovr_cnt - b_ovr); errors++; end
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h3FF) begin
            $display("FAIL b2b_held got valid=%b data=%h exp 1 3ff", bus.rx_valid, bus.rx_data); errors++;
        end
        checks++;
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        if (bus.rx_valid !== 1'b0) begin $display("FAIL b2b_valid_drop got=%b exp=0", bus.rx_valid); errors++; end
        checks++;
        if (rcv_q.size() !== rcv_rd + 1) begin $display("FAIL b2b_count got=%0d exp=1", rcv_q.size() - rcv_rd); errors++; end
        checks++;
        while (exp_q.size() > 0 && rcv_rd < rcv_q.size()) begin
            exp_w = exp_q.pop_front(); got_w = rcv_q[rcv_rd]; rcv_rd++;
            if (got_w !== exp_w) begin $display("FAIL b2b_data got=%h exp=%h", got_w, exp_w); errors++; end
            checks++;
        end
    endtask

    task automatic test_frame_error();
        bus.rx_ready = 1'b1;
        snap();
        send_frame(10'h155, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        if (ferr_cnt - b_ferr !== 1) begin $display("FAIL ferr_cycles got=%0d exp=1", ferr_cnt - b_ferr); errors++; end
        checks++;
        if (valid_cnt - b_valid !== 0 || ovr_cnt - b_ovr !== 0) begin
            $display("FAIL ferr_side got valid=%0d ovr=%0d exp 0 0", valid_cnt - b_valid, ovr_cnt - b_ovr); errors++;
        end
        checks++;
        snap();
        repeat (50 * CPB) @(posedge clk);
        #1;
        if (busy_cnt - b_busy !== 0 || bus.busy !== 1'b0) begin
            $display("FAIL break_busy got=%0d exp=0", busy_cnt - b_busy); errors++;
        end
        checks++;
        bus.rx_in = 1'b1;
        repeat (20) @(posedge clk);
        exp_q.push_back(10'h155);
        send_frame(10'h155, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        if (rcv_q.size() !== rcv_rd + 1) begin $display("FAIL rearm_count got=%0d exp=1", rcv_q.size() - rcv_rd); errors++; end
        checks++;
        while (exp_q.size() > 0 && rcv_rd < rcv_q.size()) begin
            exp_w = exp_q.pop_front(); got_w = rcv_q[rcv_rd]; rcv_rd++;
            if (got_w !== exp_w) begin $display("FAIL rearm_data got=%h exp=%h", got_w, exp_w); errors++; end
            checks++;
        end
    endtask

    task automatic test_glitch();
        snap();
        @(posedge clk);
        #1;
        bus.rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rx_in = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        if (busy_cnt - b_busy !== 8) begin $display("FAIL glitch_busy_cycles got=%0d exp=8", busy_cnt - b_busy); errors++; end
        checks++;
        if (bus.busy !== 1'b0) begin $display("FAIL glitch_busy_end got=%b exp=0", bus.busy); errors++; end
        checks++;
        if (valid_cnt - b_valid !== 0 || ferr_cnt - b_ferr !== 0 || ovr_cnt - b_ovr !== 0) begin
            $display("FAIL glitch_outputs got valid=%0d ferr=%0d ovr=%0d exp 0 0 0",
                     valid_cnt - b_valid, ferr_cnt - b_ferr, ovr_cnt - b_ovr); errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_frame();
        logic [DB-1:0] w;
        w = 10'h0F0;
        bus.rx_ready = 1'b0;
        send_frame(10'h155, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h155) begin
            $display("FAIL midrst_preload got valid=%b data=%h exp 1 155", bus.rx_valid, bus.rx_data); errors++;
        end
        checks++;
        @(posedge clk);
        #1;
        hold_bit(1'b0);
        for (int i = 0; i < 5; i++) hold_bit(w[i]);
        bus.rx_in = w[5];
        repeat (CPB / 2) @(posedge clk);
        #1;
        if (bus.busy !== 1'b1) begin $display("FAIL midrst_busy_before got=%b exp=1", bus.busy); errors++; end
        checks++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (bus.rx_valid !== 1'b0 || bus.rx_data !== '0 || bus.busy !== 1'b0 ||
            bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            $display("FAIL midrst_outputs got valid=%b data=%h busy=%b ferr=%b ovr=%b exp all 0",
                     bus.rx_valid, bus.rx_data, bus.busy, bus.frame_err, bus.overrun); errors++;
        end
        checks++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.rx_in = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        if (bus.busy !== 1'b0) begin $display("FAIL midrst_idle got=%b exp=0", bus.busy); errors++; end
        checks++;
        exp_q.push_back(10'h30C);
        send_frame(10'h30C, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        if (rcv_q.size() !== rcv_rd + 1) begin $display("FAIL midrst_count got=%0d exp=1", rcv_q.size() - rcv_rd); errors++; end
        checks++;
        while (exp_q.size() > 0 && rcv_rd < rcv_q.size()) begin
            exp_w = exp_q.pop_front(); got_w = rcv_q[rcv_rd]; rcv_rd++;
            if (got_w !== exp_w) begin $display("FAIL midrst_data got=%h exp=%h", got_w, exp_w); errors++; end
            checks++;
        end
    endtask

    task automatic test_consume_and_load();
        bus.rx_ready = 1'b0;
        exp_q.push_back(10'h111);
        send_frame(10'h111, 1'b1);
        repeat (4) @(posedge clk);
        snap();
        exp_q.push_back(10'h222);
        fork
            send_frame(10'h222, 1'b1);
            begin
                // Stop sample lands in the cycle after the 187th edge seen here.
                repeat (187) @(posedge clk);
                #1;
                bus.rx_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.rx_ready = 1'b0;
                if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h222) begin
                    $display("FAIL cl_swap got valid=%b data=%h exp 1 222", bus.rx_valid, bus.rx_data); errors++;
                end
                checks++;
            end
        join
        if (ovr_cnt - b_ovr !== 0) begin $display("FAIL cl_overrun got=%0d exp=0", ovr_cnt - b_ovr); errors++; end
        checks++;
        repeat (2) @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        if (bus.rx_valid !== 1'b0) begin $display("FAIL cl_drain got=%b exp=0", bus.rx_valid); errors++; end
        checks++;
        if (rcv_q.size() !== rcv_rd + 2) begin $display("FAIL cl_count got=%0d exp=2", rcv_q.size() - rcv_rd); errors++; end
        checks++;
        while (exp_q.size() > 0 && rcv_rd < rcv_q.size()) begin
            exp_w = exp_q.pop_front(); got_w = rcv_q[rcv_rd]; rcv_rd++;
            if (got_w !== exp_w) begin $display("FAIL cl_data got=%h exp=%h", got_w, exp_w); errors++; end
            checks++;
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.rx_in = 1'b1;
        bus.rx_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_consume_and_load();
        if (both_cnt !== 0 || exp_q.size() !== 0) begin
            $display("FAIL final_state got both=%0d pending=%0d exp 0 0", both_cnt, exp_q.size()); errors++;
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
